// File: rtl/mem_arbiter.sv
// Data-memory arbiter between the program loader and the CPU.
// Sequences boot (load, one-cycle start pulse) and bounds loader bursts in run mode.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned LD_BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_din,
  input  logic                  ld_done,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic                  cpu_stall,
  output logic                  cpu_start,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            state_out
);

  typedef enum logic [1:0] {
    StBoot    = 2'd0,
    StStart   = 2'd1,
    StRun     = 2'd2,
    StIllegal = 2'd3
  } state_e;

  localparam logic [7:0] BurstMax = 8'(LD_BURST_MAX);

  state_e                  state_q, state_d;
  logic [7:0]              burst_cnt_q, burst_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_shadow_q;
  logic [DATA_WIDTH-1:0]   din_shadow_q;
  logic                    ld_rvalid_q, cpu_rvalid_q;
  logic                    fair;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StBoot;
      burst_cnt_q   <= '0;
      addr_shadow_q <= '0;
      din_shadow_q  <= '0;
      ld_rvalid_q   <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      ld_rvalid_q  <= ld_gnt & ~ld_we;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      if (ld_gnt) begin
        addr_shadow_q <= ld_addr;
        din_shadow_q  <= ld_din;
      end else if (cpu_gnt) begin
        addr_shadow_q <= cpu_addr;
        din_shadow_q  <= cpu_din;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = StBoot;
    case (state_q)
      StBoot:  state_d = ld_done ? StStart : StBoot;
      StStart: state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  // Loader yields one slot once it has held the port for a full burst.
  assign fair = (burst_cnt_q == BurstMax) & cpu_req;

  // Output logic
  always_comb begin
    ld_gnt    = 1'b0;
    cpu_gnt   = 1'b0;
    cpu_stall = 1'b1;
    cpu_start = 1'b0;
    case (state_q)
      StBoot: ld_gnt = ld_req;
      StStart: cpu_start = 1'b1;
      StRun: begin
        ld_gnt    = ld_req & ~fair;
        cpu_gnt   = cpu_req & (~ld_req | fair);
        cpu_stall = cpu_req & ~cpu_gnt;
      end
      default: ;
    endcase

    mem_we   = 1'b0;
    mem_addr = addr_shadow_q;
    mem_din  = din_shadow_q;
    if (ld_gnt) begin
      mem_we   = ld_we;
      mem_addr = ld_addr;
      mem_din  = ld_din;
    end else if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_din;
    end

    if (reset) begin
      ld_gnt    = 1'b0;
      cpu_gnt   = 1'b0;
      cpu_stall = 1'b1;
      cpu_start = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_din   = '0;
    end

    burst_cnt_d = '0;
    if (ld_gnt) begin
      burst_cnt_d = (burst_cnt_q == BurstMax) ? burst_cnt_q : burst_cnt_q + 8'd1;
    end
  end

  assign ld_rvalid  = ld_rvalid_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign rdata      = mem_dout;
  assign state_out  = state_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single-port data memory and shares it between two requesters: the external program loader and the CPU fetch/data path.
- Sequences boot. Memory is filled while the CPU is held, then the CPU is released with a one-cycle start pulse.
- In run mode the loader keeps DMA-style priority, with a bounded burst length so the CPU cannot starve.
- Replaces the ad-hoc manual_mem muxing and the trigger_program strobe.

Parameters:
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 8, memory data width.
- LD_BURST_MAX, 4, maximum consecutive loader grants in RUN while the CPU is requesting. Legal range 1..255.

Ports:
- clk  in  1  system clock (phi2 domain).
- reset  in  1  synchronous, active-high reset.
- ld_req  in  1  loader access request.
- ld_we  in  1  loader write (1) / read (0).
- ld_addr  in  ADDR_WIDTH  loader address.
- ld_din  in  DATA_WIDTH  loader write data.
- ld_done  in  1  loader finished boot image (pulse).
- ld_gnt  out  1  loader access performed this cycle.
- ld_rvalid  out  1  rdata holds the loader's read result.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_din  in  DATA_WIDTH  CPU write data.
- cpu_gnt  out  1  CPU access performed this cycle.
- cpu_rvalid  out  1  rdata holds the CPU's read result.
- cpu_stall  out  1  CPU must hold its request/state.
- cpu_start  out  1  one-cycle CPU start pulse.
- mem_we  out  1  to memory write enable.
- mem_addr  out  ADDR_WIDTH  to memory address.
- mem_din  out  DATA_WIDTH  to memory write data.
- mem_dout  in  DATA_WIDTH  from memory (registered, 1-cycle read latency).
- rdata  out  DATA_WIDTH  equals mem_dout; qualified by the rvalid outputs.
- state_out  out  2  current state, for debug.

Behaviour:
- Reset (sampled high at a clk edge): state=BOOT, burst_cnt=0, ld_rvalid=0, cpu_rvalid=0.
- While reset is high, all combinational outputs are forced: gnt=0, mem_we=0, mem_addr=0, mem_din=0, cpu_start=0, cpu_stall=1.
- Reset mid-operation aborts any access. No write occurs in a cycle where reset is high.
- States: BOOT=0, START=1, RUN=2. Encoding 3 is illegal and returns to BOOT at the next edge.
- BOOT:
  - ld_gnt=ld_req; cpu_gnt=0; cpu_stall=1.
  - ld_done=1 moves to START at the next edge.
  - An ld_req in the same cycle as ld_done is still granted.
- START:
  - Lasts exactly one cycle; cpu_start=1; no grants; cpu_stall=1.
  - Always moves to RUN.
- RUN:
  - Default: the loader has priority. ld_gnt=ld_req; cpu_gnt=cpu_req & ~ld_req.
  - Fairness: if burst_cnt==LD_BURST_MAX and cpu_req=1, the CPU is granted and the loader is not. burst_cnt clears to 0.
  - burst_cnt increments (saturating at LD_BURST_MAX) on each ld_gnt. It clears on any cycle without ld_gnt.
  - cpu_stall = cpu_req & ~cpu_gnt.
  - ld_done is ignored.
- Memory port:
  - mem_we, mem_addr and mem_din are combinationally muxed from the granted requester.
  - With no grant: mem_we=0, and mem_addr/mem_din hold the last granted values (registered shadow, reset 0).
- Read return:
  - ld_rvalid <= ld_gnt & ~ld_we; cpu_rvalid <= cpu_gnt & ~cpu_we.
  - Asserted exactly one cycle after the granted read.
  - At most one rvalid is high per cycle.
- Exactly one of ld_gnt/cpu_gnt may be high in any cycle; never both.
- cpu_start is high only in START. It is never re-asserted without passing through reset.

Test Plan:
- Reset, then in BOOT the loader writes 0xA5 to 0x0010 and reads it back -> ld_gnt=1 both cycles, ld_rvalid=1 one cycle after the read with rdata=0xA5; cpu_stall=1 throughout; cpu_gnt=0 even with cpu_req=1.
- ld_done pulse with simultaneous ld_req write 0x3C@0x0020 -> write performed; next cycle state=START and cpu_start=1 for exactly one cycle; state=RUN after that; cpu_stall drops.
- RUN with CPU read of 0x0020, no loader activity -> cpu_gnt=1, cpu_rvalid=1 next cycle, rdata=0x3C; cpu_stall=0.
- RUN with LD_BURST_MAX=4 and ld_req and cpu_req held high for 10 cycles -> grants follow L,L,L,L,C,L,L,L,L,C; cpu_stall=1 exactly on loader cycles.
- Reset asserted mid-RUN during a CPU write to 0x0030 -> that location keeps its old value; next cycle state=BOOT, cpu_stall=1, both rvalids=0.
- RUN with ld_done pulses and no requests -> state stays RUN and cpu_start stays 0.
